// File: rtl/operand_fwd_sel_reg.sv
// Operand forwarding select with pipeline register.
// Picks one of NUM_SRC forwarding sources by binary index and registers it as
// the stage operand. Producer stages keep advancing during a load-use stall,
// so the selected value is captured on stall entry and replayed on release.
// A saturating counter records how many cycles the last stall lasted.

module operand_fwd_sel_reg #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 8,
    parameter int CNT_W   = 8,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     sel_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     recapture,
    output logic [WIDTH-1:0]         op_q,
    output logic                     op_valid,
    output logic                     sel_err,
    output logic                     held,
    output logic [CNT_W-1:0]         hold_cnt
);

    typedef enum logic [0:0] {
        RUN_S  = 1'b0,
        HOLD_S = 1'b1
    } state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_e             state_q;
    logic               op_valid_q;
    logic               sel_err_q;
    logic               held_q;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [WIDTH-1:0]   hold_op_q;
    logic               hold_v_q;
    logic               hold_err_q;

    logic [WIDTH-1:0]   cur_s;
    logic               err_s;
    logic               err_live_s;

    // Binary source pick; an index past the last source yields zero and flags an error.
    always_comb begin
        cur_s = {WIDTH{1'b0}};
        err_s = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                cur_s = src_flat[i*WIDTH +: WIDTH];
                err_s = 1'b0;
            end else begin
                cur_s = cur_s;
                err_s = err_s;
            end
        end
    end

    // An out-of-range select only matters when the stage carries a live instruction.
    assign err_live_s = err_s & sel_valid;

    // RUN/HOLD controller: flush beats stall handling, which beats a normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN_S;
            op_q       <= {WIDTH{1'b0}};
            op_valid_q <= 1'b0;
            sel_err_q  <= 1'b0;
            held_q     <= 1'b0;
            hold_cnt_q <= {CNT_W{1'b0}};
            hold_op_q  <= {WIDTH{1'b0}};
            hold_v_q   <= 1'b0;
            hold_err_q <= 1'b0;
        end else if (flush) begin
            // Kill the stage; the count of the interrupted stall is kept for observation.
            state_q    <= RUN_S;
            op_q       <= {WIDTH{1'b0}};
            op_valid_q <= 1'b0;
            sel_err_q  <= 1'b0;
            held_q     <= 1'b0;
            hold_v_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN_S: begin
                    if (stall) begin
                        // Snapshot the selection before the producers move on.
                        hold_op_q  <= cur_s;
                        hold_v_q   <= sel_valid;
                        hold_err_q <= err_live_s;
                        hold_cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
                        state_q    <= HOLD_S;
                        held_q     <= 1'b1;
                    end else begin
                        op_q       <= cur_s;
                        op_valid_q <= sel_valid;
                        sel_err_q  <= err_live_s;
                    end
                end
                HOLD_S: begin
                    if (stall) begin
                        hold_cnt_q <= sat_inc(hold_cnt_q);
                        if (recapture) begin
                            hold_op_q  <= cur_s;
                            hold_v_q   <= sel_valid;
                            hold_err_q <= err_live_s;
                        end else begin
                            hold_op_q  <= hold_op_q;
                        end
                    end else begin
                        // Release: replay the snapshot unless the hazard unit asks for a fresh pick.
                        if (recapture) begin
                            op_q       <= cur_s;
                            op_valid_q <= sel_valid;
                            sel_err_q  <= err_live_s;
                        end else begin
                            op_q       <= hold_op_q;
                            op_valid_q <= hold_v_q;
                            sel_err_q  <= hold_err_q;
                        end
                        state_q <= RUN_S;
                        held_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN_S;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign op_valid = op_valid_q;
    assign sel_err  = sel_err_q;
    assign held     = held_q;
    assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_operand_fwd_sel_reg.sv
// Bench for operand_fwd_sel_reg with five sources, so that select values 5..7
// exercise the out-of-range path. Directed scenarios are followed by a random
// run; every cycle all outputs are compared to a reference model kept here.

module tb_operand_fwd_sel_reg;

    localparam int WIDTH   = 32;
    localparam int NSRC    = 5;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic                   clk;
    logic                   rst_n;
    logic [NSRC*WIDTH-1:0]  src_flat;
    logic [2:0]             sel;
    logic                   sel_valid;
    logic                   stall;
    logic                   flush;
    logic                   recapture;
    logic [WIDTH-1:0]       op_q;
    logic                   op_valid;
    logic                   sel_err;
    logic                   held;
    logic [CNT_W-1:0]       hold_cnt;

    logic [WIDTH-1:0]       src [NSRC];

    int tests_run;
    int tests_failed;

    // Reference state: the visible operand, and a pending snapshot while stalled.
    logic [WIDTH-1:0] m_op;
    bit               m_v;
    bit               m_e;
    bit               m_stalled;
    int               m_cnt;
    logic [WIDTH-1:0] m_pend_op;
    bit               m_pend_v;
    bit               m_pend_e;

    operand_fwd_sel_reg #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NSRC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_flat  (src_flat),
        .sel       (sel),
        .sel_valid (sel_valid),
        .stall     (stall),
        .flush     (flush),
        .recapture (recapture),
        .op_q      (op_q),
        .op_valid  (op_valid),
        .sel_err   (sel_err),
        .held      (held),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the source array into the flat bus.
    always_comb begin
        src_flat = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_flat[i*WIDTH +: WIDTH] = src[i];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_op = '0; m_v = 0; m_e = 0; m_stalled = 0; m_cnt = 0;
        m_pend_op = '0; m_pend_v = 0; m_pend_e = 0;
    endtask

    // Apply one clock edge of the intended behaviour to the reference state.
    task automatic model_step();
        logic [WIDTH-1:0] cur;
        bit               bad;
        bad = (int'(sel) >= NSRC);
        cur = '0;
        if (!bad) cur = src[sel];
        if (flush) begin
            m_op = '0; m_v = 0; m_e = 0; m_pend_v = 0; m_stalled = 0;
        end else if (!m_stalled && !stall) begin
            m_op = cur; m_v = sel_valid; m_e = bad && sel_valid;
        end else if (!m_stalled) begin
            m_pend_op = cur; m_pend_v = sel_valid; m_pend_e = bad && sel_valid;
            m_cnt = 1; m_stalled = 1;
        end else if (stall) begin
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (recapture) begin
                m_pend_op = cur; m_pend_v = sel_valid; m_pend_e = bad && sel_valid;
            end
        end else begin
            if (recapture) begin
                m_op = cur; m_v = sel_valid; m_e = bad && sel_valid;
            end else begin
                m_op = m_pend_op; m_v = m_pend_v; m_e = m_pend_e;
            end
            m_stalled = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".op_q"},     op_q,     m_op);
        check_eq({tag, ".op_valid"}, op_valid, m_v);
        check_eq({tag, ".sel_err"},  sel_err,  m_e);
        check_eq({tag, ".held"},     held,     m_stalled);
        check_eq({tag, ".hold_cnt"}, hold_cnt, m_cnt[CNT_W-1:0]);
    endtask

    // One clock: inputs were set beforehand, outputs are checked 1 time unit after the edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic quiet();
        stall = 0; flush = 0; recapture = 0; sel_valid = 1; sel = 3'd0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NSRC; i++) src[i] = $urandom;
        quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst_n = 1'b1;

        // Pass-through.
        src[3] = 32'hDEAD_BEEF; sel = 3'd3; sel_valid = 1;
        cycle("pass");
        check_eq("pass_op", op_q, 64'hDEAD_BEEF);
        check_eq("pass_valid", op_valid, 64'd1);

        // Stall replay: the source changes while stalled, the snapshot survives.
        src[2] = 32'h11; sel = 3'd2; stall = 1;
        cycle("rep_in");
        check_eq("rep_held", held, 64'd1);
        src[2] = 32'h22;
        cycle("rep_s2");
        cycle("rep_s3");
        stall = 0;
        cycle("rep_out");
        check_eq("rep_op", op_q, 64'h11);
        check_eq("rep_cnt", hold_cnt, 64'd3);

        // Recapture while held, then release.
        stall = 1; sel = 3'd0;
        cycle("rc_in");
        recapture = 1; sel = 3'd4; src[4] = 32'h55;
        cycle("rc_cap");
        recapture = 0; stall = 0; sel = 3'd0; src[4] = 32'h66;
        cycle("rc_out");
        check_eq("rc_op", op_q, 64'h55);

        // Recapture on the release edge itself takes the current selection.
        stall = 1; sel = 3'd0;
        cycle("rcr_in");
        stall = 0; recapture = 1; sel = 3'd1; src[1] = 32'h77;
        cycle("rcr_out");
        check_eq("rcr_op", op_q, 64'h77);
        recapture = 0;

        // Flush together with stall wins, and nothing is replayed afterwards.
        src[1] = 32'hAA; sel = 3'd1; stall = 1;
        cycle("fl_in");
        flush = 1;
        cycle("fl_kill");
        check_eq("fl_op", op_q, 64'h0);
        check_eq("fl_valid", op_valid, 64'd0);
        check_eq("fl_held", held, 64'd0);
        flush = 0; stall = 0; src[1] = 32'hBB;
        cycle("fl_after");
        check_eq("fl_noreplay", op_q, 64'hBB);

        // Out-of-range select, live and not live.
        sel = 3'd6; sel_valid = 1;
        cycle("bad_live");
        check_eq("bad_op", op_q, 64'h0);
        check_eq("bad_err", sel_err, 64'd1);
        sel_valid = 0;
        cycle("bad_dead");
        check_eq("bad_err_supp", sel_err, 64'd0);
        check_eq("bad_valid", op_valid, 64'd0);

        // Long stall saturates the counter.
        sel_valid = 1; sel = 3'd2; stall = 1;
        for (int i = 0; i < 300; i++) cycle("sat");
        check_eq("sat_cnt", hold_cnt, 64'd255);
        stall = 0;
        cycle("sat_out");
        check_eq("sat_keep", hold_cnt, 64'd255);

        // Asynchronous reset in the middle of a stall.
        stall = 1; sel = 3'd3;
        cycle("rst_in");
        cycle("rst_s2");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        check_eq("rst_op", op_q, 64'h0);
        check_eq("rst_held", held, 64'd0);
        stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle("rst_run");

        // Randomised run.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NSRC; i++) src[i] = $urandom;
            sel       = 3'($urandom_range(7, 0));
            sel_valid = ($urandom_range(99, 0) < 80);
            stall     = ($urandom_range(99, 0) < 35);
            flush     = ($urandom_range(99, 0) < 5);
            recapture = ($urandom_range(99, 0) < 20);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
